// File: rtl/fib_stepper.sv
`default_nettype none
// ============================================================================
// fib_stepper : Fibonacci stepper advanced by synchronized rising edges of tick_in.
// Define FIB_STEPPER_BCD_EN to add a sequential double-dabble BCD output.
// Revision    : 1.0
// ============================================================================
module fib_stepper #(
  parameter int WIDTH = 16,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             start,
  input  logic             hold,
  input  logic             clear,
  output logic [WIDTH-1:0] fib_out,
  output logic [5:0]       index,
  output logic             valid,
  output logic             overflow,
  output logic             busy,
  output logic             halted
`ifdef FIB_STEPPER_BCD_EN
  ,
  output logic [4*((WIDTH*3)/10+1)-1:0] bcd_out,
  output logic                          bcd_valid
`endif
);

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  logic       sync1_q, sync2_q, sync3_q;
  logic [2:0] arm_q;
  logic       step_w;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [5:0]       idx_q, idx_d;
  logic             novf_q, novf_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             busy_q, halted_q;
  logic [WIDTH:0]   sum_w;

  // arm_q marks how many sync stages hold real samples of tick_in, so a tick
  // that is already high when reset releases cannot look like a fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      arm_q   <= 3'b000;
    end else begin
      sync1_q <= tick_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      arm_q   <= {arm_q[1:0], 1'b1};
    end
  end

  assign step_w = sync2_q & ~sync3_q & arm_q[2];
  assign sum_w  = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    novf_d  = novf_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (clear) begin
      state_d = IDLE;
      a_d     = '0;
      b_d     = c_one;
      idx_d   = '0;
      novf_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, HALT: begin
          if (start) begin
            state_d = RUN;
            a_d     = '0;
            b_d     = c_one;
            idx_d   = '0;
            novf_d  = 1'b0;
            ovf_d   = 1'b0;
          end
        end
        RUN: begin
          if (step_w && !hold) begin
            if (novf_q) begin
              ovf_d = 1'b1;
              if (WRAP) begin
                a_d     = '0;
                b_d     = c_one;
                idx_d   = '0;
                novf_d  = 1'b0;
                valid_d = 1'b1;
              end else begin
                state_d = HALT;
              end
            end else begin
              a_d     = b_q;
              b_d     = sum_w[WIDTH-1:0];
              novf_d  = sum_w[WIDTH];
              idx_d   = idx_q + 6'd1;
              valid_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= c_one;
      idx_q    <= '0;
      novf_q   <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      novf_q   <= novf_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      busy_q   <= (state_d == RUN);
      halted_q <= (state_d == HALT);
    end
  end

  assign fib_out  = a_q;
  assign index    = idx_q;
  assign valid    = valid_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign halted   = halted_q;

`ifdef FIB_STEPPER_BCD_EN
  localparam int DIGITS = (WIDTH*3)/10 + 1;
  localparam int BCDW   = 4*DIGITS;

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BCDW-1:0]  acc_q, acc_d, adj_w, bcd_q, bcd_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             bcdv_q, bcdv_d;

  always_comb begin
    adj_w = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj_w[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // The accumulator's dropped MSB (always 0) refills the binary LSB; those
  // refill bits never reach the top of bin_q within WIDTH shifts.
  always_comb begin
    bin_d  = bin_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    bcd_d  = bcd_q;
    bcdv_d = 1'b0;
    if (valid_q) begin
      bin_d = a_q;
      acc_d = '0;
      cnt_d = 6'(WIDTH);
    end else if (cnt_q != 6'd0) begin
      acc_d = {adj_w[BCDW-2:0], bin_q[WIDTH-1]};
      bin_d = {bin_q[WIDTH-2:0], adj_w[BCDW-1]};
      cnt_d = cnt_q - 6'd1;
      if (cnt_q == 6'd1) begin
        bcd_d  = acc_d;
        bcdv_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      bcd_q  <= '0;
      bcdv_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      bcd_q  <= bcd_d;
      bcdv_q <= bcdv_d;
    end
  end

  assign bcd_out   = bcd_q;
  assign bcd_valid = bcdv_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fib_stepper.sv
`default_nettype none
// ============================================================================
// tb_fib_stepper : two steppers (WRAP=1, WRAP=0) driven by shared random
// tick/hold stimulus and compared against an arithmetic Fibonacci model.
// Revision       : 1.0
// ============================================================================
module tb_fib_stepper;
  localparam int     WIDTH = 16;
  localparam longint MAXV  = (64'sd1 <<< WIDTH) - 1;

  logic clk = 1'b0;
  logic rst, tick_in, start, hold, clear;
  logic [WIDTH-1:0] fib_w, fib_h;
  logic [5:0]       idx_w, idx_h;
  logic val_w, val_h, ovf_w, ovf_h, busy_w, busy_h, hlt_w, hlt_h;
`ifdef FIB_STEPPER_BCD_EN
  localparam int BCDW = 4*((WIDTH*3)/10+1);
  logic [BCDW-1:0] bcd_w, bcd_h;
  logic            bv_w, bv_h;
`endif

  int     n_checks = 0, n_pass = 0;
  int     vcnt_w = 0, vcnt_h = 0;
  longint cyc = 0, vcyc = 0, bcyc = 0;

  // model state
  bit m_wrun, m_wovf, m_hrun, m_hhalt, m_hovf;
  int m_wn, m_hn, m_wv, m_hv;

  always #5 clk = ~clk;

  fib_stepper #(.WIDTH(WIDTH), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .hold(hold), .clear(clear),
    .fib_out(fib_w), .index(idx_w), .valid(val_w), .overflow(ovf_w), .busy(busy_w), .halted(hlt_w)
`ifdef FIB_STEPPER_BCD_EN
    , .bcd_out(bcd_w), .bcd_valid(bv_w)
`endif
  );

  fib_stepper #(.WIDTH(WIDTH), .WRAP(1'b0)) dut_h (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .hold(hold), .clear(clear),
    .fib_out(fib_h), .index(idx_h), .valid(val_h), .overflow(ovf_h), .busy(busy_h), .halted(hlt_h)
`ifdef FIB_STEPPER_BCD_EN
    , .bcd_out(bcd_h), .bcd_valid(bv_h)
`endif
  );

  always @(negedge clk) begin
    cyc++;
    if (val_w) begin vcnt_w++; vcyc = cyc; end
    if (val_h) vcnt_h++;
`ifdef FIB_STEPPER_BCD_EN
    if (bv_w) bcyc = cyc;
`endif
  end

  function automatic longint fib(input int n);
    longint a = 0, b = 1, t;
    for (int i = 0; i < n; i++) begin t = a + b; a = b; b = t; end
    return a;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_wrun = 0; m_wovf = 0; m_wn = 0;
    m_hrun = 0; m_hhalt = 0; m_hovf = 0; m_hn = 0;
  endtask

  task automatic model_start();
    if (!m_wrun) begin m_wrun = 1; m_wn = 0; m_wovf = 0; end
    if (!m_hrun) begin m_hrun = 1; m_hhalt = 0; m_hn = 0; m_hovf = 0; end
  endtask

  task automatic model_clear();
    m_wrun = 0; m_wn = 0;
    m_hrun = 0; m_hhalt = 0; m_hn = 0;
  endtask

  task automatic model_step(input bit h);
    if (!h && m_wrun) begin
      m_wv++;
      if (fib(m_wn + 1) > MAXV) begin m_wovf = 1; m_wn = 0; end
      else m_wn++;
    end
    if (!h && m_hrun) begin
      if (fib(m_hn + 1) > MAXV) begin m_hovf = 1; m_hrun = 0; m_hhalt = 1; end
      else begin m_hn++; m_hv++; end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".fib_w"},  fib_w,  fib(m_wn));
    check({tag, ".idx_w"},  idx_w,  m_wn);
    check({tag, ".ovf_w"},  ovf_w,  m_wovf);
    check({tag, ".busy_w"}, busy_w, m_wrun);
    check({tag, ".hlt_w"},  hlt_w,  0);
    check({tag, ".fib_h"},  fib_h,  fib(m_hn));
    check({tag, ".idx_h"},  idx_h,  m_hn);
    check({tag, ".ovf_h"},  ovf_h,  m_hovf);
    check({tag, ".busy_h"}, busy_h, m_hrun);
    check({tag, ".hlt_h"},  hlt_h,  m_hhalt);
    check({tag, ".vcnt_w"}, vcnt_w, m_wv);
    check({tag, ".vcnt_h"}, vcnt_h, m_hv);
  endtask

  task automatic do_tick(input int hi, input int lo);
    tick_in = 1'b1;
    repeat (hi) @(negedge clk);
    tick_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk);
    start = 1'b0; @(negedge clk);
    model_start();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit h;
    rst = 1'b1; tick_in = 1'b0; start = 1'b0; hold = 1'b0; clear = 1'b0;
    m_wv = 0; m_hv = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    @(negedge clk);

    do_tick(2, 4);
    check_all("idle_tick");
    pulse_start();
    check_all("start");

    // exact latency: update lands on the 3rd rising edge after tick rise
    tick_in = 1'b1;
    repeat (2) @(negedge clk);
    check("lat.early_valid", val_w, 0);
    check("lat.early_fib", fib_w, 0);
    @(negedge clk);
    check("lat.valid_w", val_w, 1);
    check("lat.valid_h", val_h, 1);
    check("lat.fib", fib_w, 1);
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    model_step(0);
    check_all("lat");

    for (int k = 2; k <= 10; k++) begin
      do_tick($urandom_range(1, 5), $urandom_range(3, 6));
      model_step(0);
      check_all("seq10");
    end
    check("seq10.fib55", fib_w, 55);
    check("seq10.idx10", idx_w, 10);
    check("seq10.valids", vcnt_w, 10);

    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_tick($urandom_range(1, 5), $urandom_range(3, 6));
      model_step(1);
    end
    hold = 1'b0;
    check_all("hold");

    do_tick(50, 4);
    model_step(0);
    check_all("long_tick");

    for (int k = 0; k < 100 && !m_hhalt; k++) begin
      h = ($urandom_range(0, 3) == 0);
      hold = h;
      do_tick($urandom_range(1, 5), $urandom_range(3, 6));
      hold = 1'b0;
      model_step(h);
      check_all("rand");
      if (!h && m_wn == 24) begin
        check("t24.fib", fib_w, 46368);
        check("t24.idx", idx_w, 24);
`ifdef FIB_STEPPER_BCD_EN
        repeat (20) @(negedge clk);
        check("bcd.latency", bcyc - vcyc, 17);
        check("bcd.value", bcd_w, 20'h46368);
`endif
      end
    end
    check("t25.fib_w", fib_w, 0);
    check("t25.idx_w", idx_w, 0);
    check("t25.ovf_w", ovf_w, 1);
    check("t25.busy_w", busy_w, 1);
    check("t25.hlt_h", hlt_h, 1);
    check("t25.fib_h", fib_h, 46368);
    check("t25.idx_h", idx_h, 24);
    check("t25.vcnt_h", vcnt_h, 24);

    do_tick(2, 4);
    model_step(0);
    check_all("halted_tick");
    pulse_start();
    check_all("restart");
    check("restart.fib_h", fib_h, 0);
    check("restart.ovf_h", ovf_h, 0);

    // clear held exactly in the cycle the internal step is active
    tick_in = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; tick_in = 1'b0;
    repeat (3) @(negedge clk);
    model_clear();
    check_all("clear_tick");

    pulse_start();
    for (int k = 0; k < 7; k++) begin
      do_tick($urandom_range(1, 5), $urandom_range(3, 6));
      model_step(0);
    end
    check_all("pre_rst");
    tick_in = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    tick_in = 1'b0;
    do_tick(2, 4);
    check_all("rst_no_step");

    // tick high through reset release, start right away: no phantom step
    tick_in = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    repeat (4) @(negedge clk);
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
    check_all("rel_high");
    do_tick(2, 4);
    model_step(0);
    check_all("post_rel_step");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fib_stepper.md
FIB_STEPPER -- requirements
Module: fib_stepper

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, setting the Fibonacci term width in bits (legal range 8..32).
REQ-002 The block SHALL have parameter WRAP, default 1: 1 = restart the sequence on overflow, 0 = halt on overflow.
REQ-003 The block SHALL use one clock and asynchronous, active-high reset, as already decided.
REQ-004 Port `clk`: input, 1 bit, system clock.
REQ-005 Port `rst`: input, 1 bit, asynchronous active-high reset.
REQ-006 Port `tick_in`: input, 1 bit, slow clock from the clock-divider stage, treated as asynchronous data.
REQ-007 Port `start`: input, 1 bit, level, synchronous to `clk`; begins or restarts the sequence.
REQ-008 Port `hold`: input, 1 bit, level; freezes stepping while high.
REQ-009 Port `clear`: input, 1 bit, level; synchronous return to IDLE.
REQ-010 Port `fib_out`: output, WIDTH bits, current term F(index).
REQ-011 Port `index`: output, 6 bits, term number n.
REQ-012 Port `valid`: output, 1 bit, one-cycle pulse when `fib_out` and `index` take a new value.
REQ-013 Port `overflow`: output, 1 bit, sticky flag marking that the next term exceeded WIDTH bits.
REQ-014 Port `busy`: output, 1 bit, high in state RUN.
REQ-015 Port `halted`: output, 1 bit, high in state HALT.

Function
REQ-016 `tick_in` SHALL pass through a 2-flop synchronizer; a rising edge of the synchronized signal SHALL produce a one-cycle internal step pulse.
REQ-017 A single `tick_in` high period SHALL give exactly one step, however many `clk` cycles it lasts.
REQ-018 When a step is accepted, `fib_out` and `index` SHALL update on the 3rd rising `clk` edge at or after the `tick_in` rise, and `valid` SHALL be high for that same cycle only.
REQ-019 Internal registers SHALL be a (the term shown on `fib_out`), b (the next term) and nxt_ovf.
REQ-020 States SHALL be IDLE, RUN and HALT. Input priority per cycle SHALL be `clear` > `start` > step.
REQ-021 In IDLE: `clear` keeps IDLE. `start` loads a=0, b=1, index=0, nxt_ovf=0, clears `overflow` and goes to RUN. A step is ignored.
REQ-022 In RUN, a step with `hold`=0 and nxt_ovf=0 SHALL perform: a<=b; b<=(a+b) mod 2^WIDTH; nxt_ovf<=carry out of the (WIDTH+1)-bit sum; index<=index+1.
REQ-023 In RUN, a step with nxt_ovf=1 SHALL set `overflow`. If WRAP=1 it SHALL load a=0, b=1, index=0, nxt_ovf=0, pulse `valid` and stay in RUN. If WRAP=0 it SHALL go to HALT with a, b and index unchanged and no `valid`.
REQ-024 In RUN, a step with `hold`=1 SHALL be discarded, not deferred.
REQ-025 In RUN, `start` SHALL be ignored, and `clear` SHALL go to IDLE with a=0, b=1, index=0.
REQ-026 In HALT: `start` reloads as in REQ-021 and goes to RUN, `clear` goes to IDLE, and steps are ignored.
REQ-027 If `start` and a step coincide in IDLE, the block SHALL only enter RUN; the first term advance needs a later step.
REQ-028 `busy` and `halted` SHALL be registered decodes of the state, consistent with the state in the same cycle.

Reset
REQ-029 Asserting `rst` SHALL immediately force IDLE, a=0, b=1, index=0, nxt_ovf=0 and clear the synchronizer flops.
REQ-030 While `rst` is asserted, outputs SHALL be `fib_out`=0, `index`=0, `valid`=0, `overflow`=0, `busy`=0, `halted`=0.
REQ-031 Reset asserted mid-sequence SHALL abort the sequence. After release, the block SHALL accept no step until `start`.
REQ-032 A `tick_in` that is already high at reset release SHALL NOT generate a step.

Configuration
REQ-033 Macro FIB_STEPPER_BCD_EN, when defined, SHALL add outputs `bcd_out` (4*D bits, D=(WIDTH*3)/10+1) and `bcd_valid` (1 bit).
REQ-034 With FIB_STEPPER_BCD_EN, each `valid` SHALL start a sequential double-dabble conversion of `fib_out`.
REQ-035 `bcd_valid` SHALL pulse for one cycle exactly WIDTH+1 cycles after `valid`.
REQ-036 `bcd_out` SHALL hold its last result until the next conversion completes.
REQ-037 A new `valid` during a conversion SHALL restart the conversion.
REQ-038 `bcd_out` and `bcd_valid` SHALL reset to 0.
REQ-039 Without FIB_STEPPER_BCD_EN, the ports and the conversion logic SHALL be absent.

Verification
REQ-040 Reset, `start`, 10 `tick_in` pulses -> `fib_out` takes 1,1,2,3,5,8,13,21,34,55; `index`=10; 10 `valid` pulses.
REQ-041 WIDTH=16, WRAP=1, 25 ticks after `start` -> tick 24 gives 46368 with index 24; tick 25 gives `fib_out`=0, index 0, `overflow`=1, `busy`=1.
REQ-042 WIDTH=16, WRAP=0, 25 ticks -> `halted`=1, `fib_out`=46368, index 24, no 25th `valid`; then `start` -> `fib_out`=0, `overflow`=0.
REQ-043 `tick_in` held high 50 cycles -> one step only; ticks during `hold`=1 -> no change; `clear` and a tick in the same cycle -> IDLE, `fib_out`=0.
REQ-044 `rst` pulsed at index 7 with `tick_in` high -> all outputs 0 immediately; no step after release until `start`.
REQ-045 FIB_STEPPER_BCD_EN, WIDTH=16, `fib_out`=46368 -> `bcd_out`=0x46368 and `bcd_valid` pulse 17 cycles after `valid`.
